// File: rtl/regfile_sched.sv
// regfile_sched: access scheduler for a 64x32 dual-port synchronous register file.
// Port A serves ALU writeback and operand A reads. Port B is shared by host
// access, the load-writeback queue and operand B reads.
// Optional scoreboard (stalls reads of registers with outstanding loads) is
// enabled by defining REGSCHED_SCOREBOARD_EN.
module regfile_sched #(
  parameter int unsigned LDQ_DEPTH    = 4,
  parameter int unsigned HOST_MAXWAIT = 8
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        rd_req,
  input  logic [5:0]  rd_a,
  input  logic [5:0]  rd_b,
  output logic        rd_gnt,
  output logic        rd_valid,
  output logic [31:0] rd_qa,
  output logic [31:0] rd_qb,
  input  logic        alu_we,
  input  logic [5:0]  alu_wa,
  input  logic [31:0] alu_wd,
  input  logic        ld_issue,
  input  logic [5:0]  ld_dst,
  input  logic        ld_we,
  input  logic [5:0]  ld_wa,
  input  logic [31:0] ld_wd,
  output logic        ld_full,
  output logic [63:0] sb_busy,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [5:0]  host_addr,
  input  logic [31:0] host_wd,
  output logic        host_ack,
  output logic [31:0] host_rd,
  output logic        nwea,
  output logic        clka,
  output logic [5:0]  aa,
  output logic [31:0] da,
  output logic        nweb,
  output logic        clkb,
  output logic [5:0]  ab,
  output logic [31:0] db,
  input  logic [31:0] qa,
  input  logic [31:0] qb
);

  localparam int unsigned PTR_W  = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (HOST_MAXWAIT > 0) ? $clog2(HOST_MAXWAIT + 1) : 1;

  // Load-writeback queue storage and pointers
  logic [5:0]        ldq_wa_q [LDQ_DEPTH];
  logic [31:0]       ldq_wd_q [LDQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WAIT_W-1:0] host_wait_q, host_wait_d;
  logic              host_ack_q, host_ack_d;
  logic              rd_valid_q, rd_valid_d;

  logic        q_empty, q_full;
  logic [5:0]  head_wa;
  logic [31:0] head_wd;
  logic        head_conflict;
  logic        host_pend, host_urgent, host_gnt;
  logic        rd_gnt_c, b_queue, drain, push;
  logic        sb_hit;

  assign q_empty       = (cnt_q == '0);
  assign q_full        = (cnt_q == CNT_W'(LDQ_DEPTH));
  assign head_wa       = ldq_wa_q[rd_ptr_q];
  assign head_wd       = ldq_wd_q[rd_ptr_q];
  assign head_conflict = alu_we & (alu_wa == head_wa);

  // A request seen in its own ack cycle is the one just served, not a new one.
  assign host_pend   = resetl & host_req & ~host_ack_q;
  assign host_urgent = host_pend & (host_wait_q == WAIT_W'(HOST_MAXWAIT));

`ifdef REGSCHED_SCOREBOARD_EN
  logic [63:0] sb_q, sb_d;
  assign sb_hit  = sb_q[rd_a] | sb_q[rd_b];
  assign sb_busy = sb_q;
`else
  logic unused_ld_issue;
  assign unused_ld_issue = ^{ld_issue, ld_dst};
  assign sb_hit  = 1'b0;
  assign sb_busy = '0;
`endif

  // Port B arbitration: urgent host > full queue > operand read > queue > host.
  // A queue head blocked by a same-address ALU write leaves port B idle.
  assign rd_gnt_c = resetl & rd_req & ~alu_we & ~host_urgent & ~q_full & ~sb_hit;
  assign b_queue  = ~host_urgent & ~rd_gnt_c & ~q_empty;
  assign drain    = resetl & b_queue & ~head_conflict;
  assign host_gnt = host_urgent | (~rd_gnt_c & q_empty & host_pend);
  assign push     = resetl & ld_we & (~q_full | drain);

  assign rd_gnt   = rd_gnt_c;
  assign rd_valid = rd_valid_q;
  assign rd_qa    = qa;
  assign rd_qb    = qb;
  assign ld_full  = q_full;
  assign host_ack = host_ack_q;
  assign host_rd  = qb;

  // Port A: ALU writeback wins over operand A read; idle during reset
  always_comb begin
    clka = 1'b0;
    nwea = 1'b1;
    aa   = '0;
    da   = '0;
    if (resetl && alu_we) begin
      clka = 1'b1;
      nwea = 1'b0;
      aa   = alu_wa;
      da   = alu_wd;
    end else if (rd_gnt_c) begin
      clka = 1'b1;
      aa   = rd_a;
    end
  end

  // Port B: drive whichever requester won arbitration
  always_comb begin
    clkb = 1'b0;
    nweb = 1'b1;
    ab   = '0;
    db   = '0;
    if (host_gnt) begin
      clkb = 1'b1;
      nweb = ~host_wr;
      ab   = host_addr;
      db   = host_wd;
    end else if (drain) begin
      clkb = 1'b1;
      nweb = 1'b0;
      ab   = head_wa;
      db   = head_wd;
    end else if (rd_gnt_c) begin
      clkb = 1'b1;
      ab   = rd_b;
    end
  end

  // Next-state for queue pointers, host wait counter and response strobes
  always_comb begin
    wr_ptr_d    = push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = drain ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(drain);
    host_wait_d = host_wait_q;
    if (host_gnt) begin
      host_wait_d = '0;
    end else if (host_pend && (host_wait_q != WAIT_W'(HOST_MAXWAIT))) begin
      host_wait_d = host_wait_q + WAIT_W'(1);
    end
    rd_valid_d = rd_gnt_c;
    host_ack_d = host_gnt;
  end

  // Control state registers
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      host_wait_q <= '0;
      rd_valid_q  <= 1'b0;
      host_ack_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      host_wait_q <= host_wait_d;
      rd_valid_q  <= rd_valid_d;
      host_ack_q  <= host_ack_d;
    end
  end

  // Queue payload storage; contents are only meaningful below cnt_q
  always_ff @(posedge sys_clk) begin
    if (push) begin
      ldq_wa_q[wr_ptr_q] <= ld_wa;
      ldq_wd_q[wr_ptr_q] <= ld_wd;
    end
  end

`ifdef REGSCHED_SCOREBOARD_EN
  // Scoreboard update: drain clears, issue sets, set applied last so it wins
  always_comb begin
    sb_d = sb_q;
    if (drain) sb_d[head_wa] = 1'b0;
    if (ld_issue) sb_d[ld_dst] = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) sb_q <= '0;
    else         sb_q <= sb_d;
  end
`endif

endmodule
